// File: rtl/hazard_nop_ctrl_if.sv
// Fetch-to-decode bus around the hazard NOP selector: fetched word in, filtered word out.
// Combinational pass-through; stall freezes state only, hold_pc is the refetch request.
interface hazard_nop_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic [31:0]      inst_in;
  logic             inst_valid;
  logic [31:0]      inst_out;
  logic             nop_sel;
  logic             hold_pc;
  logic [2:0]       bubble_cnt;
  logic [CNT_W-1:0] nop_total;

  modport master (
    output stall, inst_in, inst_valid,
    input  inst_out, nop_sel, hold_pc, bubble_cnt, nop_total
  );

  modport slave (
    input  stall, inst_in, inst_valid,
    output inst_out, nop_sel, hold_pc, bubble_cnt, nop_total
  );
endinterface

// File: rtl/hazard_nop_ctrl.sv
// RV32I fetch-to-decode hazard filter: NOP bubbles for branch shadow, JALR rs1 dependency, load-use.
// Zero-cycle inst_in->inst_out; stall freezes all state, hold_pc requests a refetch of inst_in.
module hazard_nop_ctrl #(
  parameter int          DEPTH      = 2,
  parameter int          BR_BUBBLES = 1,
  parameter int          JALR_DEP   = 1,
  parameter int          LOAD_USE   = 1,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  hazard_nop_ctrl_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0]       BR_LOAD = 3'(BR_BUBBLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    SEL_BRANCH,
    SEL_JALR,
    SEL_LOAD,
    SEL_IDLE,
    SEL_ISSUE
  } sel_e;

  function automatic logic writes_rd(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    writes_rd = (op inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR})
                && (i[11:7] != 5'd0);
  endfunction

  function automatic logic uses_rs1(input logic [31:0] i);
    uses_rs1 = !(i[6:0] inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  endfunction

  function automatic logic uses_rs2(input logic [31:0] i);
    uses_rs2 = i[6:0] inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  endfunction

  logic [31:0]      hist [DEPTH];
  logic [2:0]       cnt;
  logic [CNT_W-1:0] nop_total;

  logic        jalr_hit;
  logic        load_hit;
  sel_e        sel;
  logic        nop_sel;
  logic        hold_pc;
  logic        count_evt;
  logic [31:0] inst_out;

  // JALR reads rs1 in decode, so any in-flight writer in the window blocks it.
  always_comb begin
    jalr_hit = 1'b0;
    if ((JALR_DEP != 0) && bus.inst_valid && (bus.inst_in[6:0] == OPC_JALR)) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (writes_rd(hist[k]) && (hist[k][11:7] == bus.inst_in[19:15])) begin
          jalr_hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    load_hit = 1'b0;
    if ((LOAD_USE != 0) && bus.inst_valid
        && (hist[0][6:0] == OPC_LOAD) && writes_rd(hist[0])) begin
      load_hit = (uses_rs1(bus.inst_in) && (bus.inst_in[19:15] == hist[0][11:7]))
              || (uses_rs2(bus.inst_in) && (bus.inst_in[24:20] == hist[0][11:7]));
    end
  end

  always_comb begin
    sel = SEL_ISSUE;
    if (cnt != 3'd0) begin
      sel = SEL_BRANCH;
    end else if (jalr_hit) begin
      sel = SEL_JALR;
    end else if (load_hit) begin
      sel = SEL_LOAD;
    end else if (!bus.inst_valid) begin
      sel = SEL_IDLE;
    end
  end

  always_comb begin
    nop_sel   = 1'b1;
    hold_pc   = 1'b0;
    count_evt = 1'b0;
    unique case (sel)
      SEL_BRANCH: begin
        // Wrong-path fetch is dropped; the redirect comes from the branch unit.
        count_evt = 1'b1;
      end
      SEL_JALR, SEL_LOAD: begin
        hold_pc   = 1'b1;
        count_evt = 1'b1;
      end
      SEL_IDLE: begin
        nop_sel = 1'b1;
      end
      SEL_ISSUE: begin
        nop_sel = 1'b0;
      end
      default: begin
        nop_sel = 1'b1;
      end
    endcase
    inst_out = nop_sel ? NOP_INST : bus.inst_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        hist[k] <= NOP_INST;
      end
      cnt       <= 3'd0;
      nop_total <= '0;
    end else if (!bus.stall) begin
      hist[0] <= inst_out;
      for (int k = 1; k < DEPTH; k++) begin
        hist[k] <= hist[k-1];
      end

      // A branch seen inside the shadow is wrong-path and never reloads the counter.
      if (cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end else if (!nop_sel && (bus.inst_in[6:0] == OPC_BRANCH)) begin
        cnt <= BR_LOAD;
      end

      if (count_evt && (nop_total != CNT_MAX)) begin
        nop_total <= nop_total + CNT_W'(1);
      end
    end
  end

  assign bus.inst_out   = inst_out;
  assign bus.nop_sel    = nop_sel;
  assign bus.hold_pc    = hold_pc;
  assign bus.bubble_cnt = cnt;
  assign bus.nop_total  = nop_total;

endmodule

// File: tb/tb_hazard_nop_ctrl.sv
// Directed bench for hazard_nop_ctrl: two instances with different parameters share one
// stimulus stream and are checked every cycle against a behavioural model plus literal points.
module tb_hazard_nop_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] BEQ    = 32'h0020_8063;
  localparam logic [31:0] ADD3   = 32'h0020_81B3;
  localparam logic [31:0] ADDI5  = 32'h0010_0293;
  localparam logic [31:0] ADDI0  = 32'h0010_0013;
  localparam logic [31:0] JALR5  = 32'h0002_8067;
  localparam logic [31:0] LW6    = 32'h0000_A303;
  localparam logic [31:0] ADD_R1 = 32'h0023_03B3;
  localparam logic [31:0] ADD_R2 = 32'h0061_03B3;
  localparam logic [31:0] ADD_X8 = 32'h0084_03B3;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        valid;
  logic [31:0] inst;

  int tests = 0;
  int fails = 0;
  bit model_ok = 1'b0;

  always #5 clk = ~clk;

  hazard_nop_ctrl_if #(.CNT_W(16)) ifa ();
  hazard_nop_ctrl_if #(.CNT_W(2))  ifb ();

  assign ifa.stall      = stall;
  assign ifa.inst_in    = inst;
  assign ifa.inst_valid = valid;
  assign ifb.stall      = stall;
  assign ifb.inst_in    = inst;
  assign ifb.inst_valid = valid;

  hazard_nop_ctrl #(
    .DEPTH(2), .BR_BUBBLES(2), .JALR_DEP(1), .LOAD_USE(1), .CNT_W(16), .NOP_INST(NOP)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  hazard_nop_ctrl #(
    .DEPTH(3), .BR_BUBBLES(1), .JALR_DEP(1), .LOAD_USE(1), .CNT_W(2), .NOP_INST(NOP)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // ---------------- behavioural model ----------------
  typedef enum {K_BR, K_DEP, K_LU, K_IDLE, K_ISSUE} kind_t;

  logic [31:0] m_hist [2][4];
  int          m_cnt  [2];
  int          m_total[2];

  kind_t       exp_kind[2];
  logic [31:0] exp_out [2];

  function automatic int depth_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int bubbles_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int total_max(input int k);
    return (k == 0) ? 65535 : 3;
  endfunction

  // Destination register, 0 when the instruction has no architectural result.
  function automatic int dest(input logic [31:0] i);
    case (i[6:0])
      7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67: return int'(i[11:7]);
      default: return 0;
    endcase
  endfunction

  function automatic bit reads_reg(input logic [31:0] i, input int r);
    bit r1, r2;
    r1 = !(i[6:0] inside {7'h37, 7'h17, 7'h6F});
    r2 = i[6:0] inside {7'h33, 7'h23, 7'h63};
    return (r != 0) && ((r1 && int'(i[19:15]) == r) || (r2 && int'(i[24:20]) == r));
  endfunction

  function automatic kind_t classify(input int k);
    if (m_cnt[k] > 0) return K_BR;
    if (!valid) return K_IDLE;
    if (inst[6:0] == 7'h67) begin
      for (int j = 0; j < depth_of(k); j++) begin
        if (dest(m_hist[k][j]) != 0 && dest(m_hist[k][j]) == int'(inst[19:15])) return K_DEP;
      end
    end
    if (m_hist[k][0][6:0] == 7'h03 && reads_reg(inst, dest(m_hist[k][0]))) return K_LU;
    return K_ISSUE;
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      exp_kind[k] = classify(k);
      exp_out[k]  = (exp_kind[k] == K_ISSUE) ? inst : NOP;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 4; j++) m_hist[k][j] <= NOP;
        m_cnt[k]   <= 0;
        m_total[k] <= 0;
      end
      model_ok <= 1'b1;
    end else if (!stall) begin
      for (int k = 0; k < 2; k++) begin
        m_hist[k][0] <= exp_out[k];
        for (int j = 1; j < 4; j++) m_hist[k][j] <= m_hist[k][j-1];
        if (m_cnt[k] > 0)
          m_cnt[k] <= m_cnt[k] - 1;
        else if (exp_kind[k] == K_ISSUE && inst[6:0] == 7'h63)
          m_cnt[k] <= bubbles_of(k);
        if (exp_kind[k] inside {K_BR, K_DEP, K_LU} && m_total[k] < total_max(k))
          m_total[k] <= m_total[k] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      check("a_inst_out", ifa.inst_out, exp_out[0]);
      check("a_nop_sel", 32'(ifa.nop_sel), 32'(exp_kind[0] != K_ISSUE));
      check("a_hold_pc", 32'(ifa.hold_pc), 32'(exp_kind[0] inside {K_DEP, K_LU}));
      check("a_bubble_cnt", 32'(ifa.bubble_cnt), 32'(m_cnt[0]));
      check("a_nop_total", 32'(ifa.nop_total), 32'(m_total[0]));
      check("b_inst_out", ifb.inst_out, exp_out[1]);
      check("b_nop_sel", 32'(ifb.nop_sel), 32'(exp_kind[1] != K_ISSUE));
      check("b_hold_pc", 32'(ifb.hold_pc), 32'(exp_kind[1] inside {K_DEP, K_LU}));
      check("b_bubble_cnt", 32'(ifb.bubble_cnt), 32'(m_cnt[1]));
      check("b_nop_total", 32'(ifb.nop_total), 32'(m_total[1]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic r, input logic s, input logic v, input logic [31:0] i);
    @(posedge clk);
    #1;
    rst = r; stall = s; valid = v; inst = i;
    #2;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, NOP);
    drive(1'b1, 1'b0, 1'b0, NOP);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; valid = 1'b0; inst = NOP;
    do_reset();
    check("reset_bubble_cnt", 32'(ifa.bubble_cnt), 32'd0);
    check("reset_nop_total", 32'(ifa.nop_total), 32'd0);
    check("reset_idle_nop_sel", 32'(ifa.nop_sel), 32'd1);
    check("reset_idle_out", ifa.inst_out, NOP);

    // Branch shadow of two bubbles
    drive(1'b0, 1'b0, 1'b1, BEQ);
    check("t1_beq_out", ifa.inst_out, BEQ);
    drive(1'b0, 1'b0, 1'b1, ADD3);
    check("t1_c2_cnt", 32'(ifa.bubble_cnt), 32'd2);
    check("t1_c2_out", ifa.inst_out, NOP);
    check("t1_c2_hold", 32'(ifa.hold_pc), 32'd0);
    drive(1'b0, 1'b0, 1'b1, ADD3);
    check("t1_c3_cnt", 32'(ifa.bubble_cnt), 32'd1);
    check("t1_c3_nop_sel", 32'(ifa.nop_sel), 32'd1);
    drive(1'b0, 1'b0, 1'b1, ADD3);
    check("t1_c4_out", ifa.inst_out, ADD3);
    check("t1_c4_total", 32'(ifa.nop_total), 32'd2);

    // JALR on a freshly written rs1, then rd=x0 writer, then writer outside the window
    do_reset();
    drive(1'b0, 1'b0, 1'b1, ADDI5);
    drive(1'b0, 1'b0, 1'b1, JALR5);
    check("t2_c1_hold", 32'(ifa.hold_pc), 32'd1);
    drive(1'b0, 1'b0, 1'b1, JALR5);
    check("t2_c2_hold", 32'(ifa.hold_pc), 32'd1);
    drive(1'b0, 1'b0, 1'b1, JALR5);
    check("t2_c3_out", ifa.inst_out, JALR5);
    check("t2_total", 32'(ifa.nop_total), 32'd2);
    drive(1'b0, 1'b0, 1'b1, ADDI0);
    drive(1'b0, 1'b0, 1'b1, JALR5);
    check("t2_x0_out", ifa.inst_out, JALR5);
    drive(1'b0, 1'b0, 1'b1, ADDI5);
    drive(1'b0, 1'b0, 1'b1, ADD3);
    drive(1'b0, 1'b0, 1'b1, ADD3);
    drive(1'b0, 1'b0, 1'b1, JALR5);
    check("t2_window_out", ifa.inst_out, JALR5);
    check("t2_window_b_hold", 32'(ifb.hold_pc), 32'd1);

    // Load-use on rs1, on rs2, and an unrelated consumer
    do_reset();
    drive(1'b0, 1'b0, 1'b1, LW6);
    drive(1'b0, 1'b0, 1'b1, ADD_R1);
    check("t3_rs1_hold", 32'(ifa.hold_pc), 32'd1);
    drive(1'b0, 1'b0, 1'b1, ADD_R1);
    check("t3_rs1_issue", ifa.inst_out, ADD_R1);
    drive(1'b0, 1'b0, 1'b1, LW6);
    drive(1'b0, 1'b0, 1'b1, ADD_R2);
    check("t3_rs2_hold", 32'(ifa.hold_pc), 32'd1);
    drive(1'b0, 1'b0, 1'b1, ADD_R2);
    check("t3_rs2_issue", ifa.inst_out, ADD_R2);
    drive(1'b0, 1'b0, 1'b1, LW6);
    drive(1'b0, 1'b0, 1'b1, ADD_X8);
    check("t3_x8_issue", ifa.inst_out, ADD_X8);
    check("t3_total", 32'(ifa.nop_total), 32'd2);

    // Stall frozen inside the branch shadow
    do_reset();
    drive(1'b0, 1'b0, 1'b1, BEQ);
    drive(1'b0, 1'b0, 1'b1, ADD3);
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 1'b1, 1'b1, ADD3);
      check("t4_stall_cnt", 32'(ifa.bubble_cnt), 32'd1);
      check("t4_stall_total", 32'(ifa.nop_total), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b1, ADD3);
    check("t4_release_nop", 32'(ifa.nop_sel), 32'd1);
    drive(1'b0, 1'b0, 1'b1, ADD3);
    check("t4_done_out", ifa.inst_out, ADD3);
    check("t4_done_total", 32'(ifa.nop_total), 32'd2);

    // Reset beats stall mid-bubble
    do_reset();
    drive(1'b0, 1'b0, 1'b1, ADDI5);
    drive(1'b0, 1'b0, 1'b1, BEQ);
    drive(1'b0, 1'b0, 1'b1, ADD3);
    drive(1'b1, 1'b1, 1'b0, NOP);
    check("t5_pre_cnt", 32'(ifa.bubble_cnt), 32'd1);
    drive(1'b0, 1'b0, 1'b1, JALR5);
    check("t5_cnt", 32'(ifa.bubble_cnt), 32'd0);
    check("t5_total", 32'(ifa.nop_total), 32'd0);
    check("t5_jalr_out", ifa.inst_out, JALR5);
    check("t5_jalr_hold", 32'(ifa.hold_pc), 32'd0);

    // Counter saturation and uncounted idle fetches
    do_reset();
    for (int n = 0; n < 5; n++) begin
      drive(1'b0, 1'b0, 1'b1, LW6);
      drive(1'b0, 1'b0, 1'b1, ADD_R1);
      drive(1'b0, 1'b0, 1'b1, ADD_R1);
    end
    drive(1'b0, 1'b0, 1'b0, ADD_R1);
    check("t6_idle_nop_sel", 32'(ifa.nop_sel), 32'd1);
    check("t6_idle_hold", 32'(ifa.hold_pc), 32'd0);
    drive(1'b0, 1'b0, 1'b0, ADD_R1);
    check("t6_a_total", 32'(ifa.nop_total), 32'd5);
    check("t6_b_saturated", 32'(ifb.nop_total), 32'd3);

    // Branch in the shadow does not reload
    do_reset();
    drive(1'b0, 1'b0, 1'b1, BEQ);
    drive(1'b0, 1'b0, 1'b1, BEQ);
    drive(1'b0, 1'b0, 1'b1, BEQ);
    check("t7_c3_cnt", 32'(ifa.bubble_cnt), 32'd1);
    drive(1'b0, 1'b0, 1'b1, ADD3);
    check("t7_c4_cnt", 32'(ifa.bubble_cnt), 32'd0);
    check("t7_c4_out", ifa.inst_out, ADD3);

    drive(1'b0, 1'b0, 1'b0, NOP);
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_nop_ctrl.md
Name: hazard_nop_ctrl

Overview:
- Parametrised successor to the single-cycle branch/JALR NOP selector in the RV32I fetch-to-decode path.
- Sits between icache_dout and the decode pipeline register.
- Keeps a DEPTH-entry history of issued instructions and a bubble counter, and injects configurable NOP bubbles for three hazards: branch resolution, JALR rs1 dependency, and load-use.
- Exports a fetch-hold request and a saturating injected-NOP performance counter.

Parameters:
- DEPTH, 2, number of previously issued instructions checked for rd dependency (1..4).
- BR_BUBBLES, 1, NOPs issued after every issued BRANCH (0..7; 0 disables).
- JALR_DEP, 1, 1 enables the JALR rs1-vs-history rd check.
- LOAD_USE, 1, 1 enables the load-use check against history entry 0 only.
- CNT_W, 16, width of nop_total.
- NOP_INST, 32'h00000013, encoding injected as a bubble (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  pipeline stall; freezes all state.
- inst_in  in  32  fetched instruction (icache_dout).
- inst_valid  in  1  inst_in is meaningful this cycle.
- inst_out  out  32  instruction to decode register: inst_in or NOP_INST.
- nop_sel  out  1  1 when inst_out is NOP_INST because of a hazard or invalid fetch.
- hold_pc  out  1  1 when the fetched instruction must be re-fetched next cycle (PC must not advance).
- bubble_cnt  out  3  remaining branch bubbles.
- nop_total  out  CNT_W  count of hazard-injected NOPs, saturating.

Behaviour:
- State: hist[0..DEPTH-1] (hist[0] = most recently issued), cnt[2:0], nop_total.
- Reset (rst=1 at clk edge): all hist = NOP_INST, cnt=0, nop_total=0. While state is in reset, outputs evaluate to inst_out=NOP_INST if inst_valid=0, nop_sel=1 when inst_valid=0, hold_pc=0, bubble_cnt=0.
- Decoding (opcode = inst[6:0], rd = [11:7], rs1 = [19:15], rs2 = [24:20]):
  - writes_rd: OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR, with rd != 0.
  - uses_rs1: all except LUI, AUIPC, JAL.
  - uses_rs2: OP, STORE, BRANCH.
  - Register x0 never matches.
- Combinational decision, evaluated in priority order:
  1. cnt != 0: branch bubble. nop_sel=1, hold_pc=0 (wrong-path fetch discarded; external PC redirect).
  2. JALR_DEP=1 and inst_in is JALR and rs1 equals rd of some hist[k] (k<DEPTH) with writes_rd: dependency. nop_sel=1, hold_pc=1.
  3. LOAD_USE=1 and hist[0] is LOAD with writes_rd, and its rd matches inst_in rs1 (uses_rs1) or rs2 (uses_rs2): load-use. nop_sel=1, hold_pc=1.
  4. inst_valid=0: nop_sel=1, hold_pc=0, not counted.
  5. Otherwise: issue inst_in, nop_sel=0, hold_pc=0.
- Checks 2 and 3 apply only when inst_valid=1.
- inst_out = NOP_INST when nop_sel=1, else inst_in.
- Sequential update on edge with stall=0 and rst=0:
  - hist shifts: hist[0] <= inst_out, hist[k] <= hist[k-1].
  - cnt: if cnt != 0, cnt <= cnt-1. Else if an issued (non-NOP) inst_out is BRANCH, cnt <= BR_BUBBLES. Else cnt stays.
  - nop_total increments when priority 1, 2 or 3 fires. It holds at 2^CNT_W-1.
- Dependency clears naturally as NOPs shift into hist. Maximum JALR hold is DEPTH cycles; load-use hold is exactly 1 cycle.
- stall=1: no state changes. Outputs remain combinational on current inputs, so hold_pc and nop_sel stay consistent while frozen.
- rst has priority over stall.
- Back-to-back branches: a branch arriving while cnt != 0 is a wrong-path fetch and becomes a NOP. It does not reload cnt.
- Latency: zero-cycle combinational path from inst_in to inst_out. All hazard state is visible one cycle after issue.

Test Plan:
1. Reset, then BR_BUBBLES=2: issue beq x1,x2 (0x00208063), then two fetches of add (0x002081B3) -> cycles 2–3 inst_out=0x00000013, nop_sel=1, hold_pc=0, bubble_cnt 2→1→0, nop_total=2. Cycle 4 passes the add.
2. DEPTH=2: issue addi x5,x0,1 (0x00100293), then jalr x0,0(x5) (0x00028067) -> 2 cycles nop_sel=1, hold_pc=1, then jalr issued, nop_total=2. Same sequence with rd=x0 -> 0 bubbles.
3. lw x6,0(x1) (0x0000A303) followed by add x7,x6,x2 (0x002303B3) -> exactly 1 NOP with hold_pc=1, then the add issues. Same with rs2=x6 also stalls 1. With the add using only x8 -> 0 bubbles.
4. During a branch bubble assert stall=1 for 3 cycles -> bubble_cnt, hist and nop_total unchanged. On release, the remaining bubbles complete.
5. Assert rst mid-bubble (cnt=1) with stall=1 -> next cycle cnt=0, nop_total=0, hist all NOP. A JALR on x5 then issues with no stall.
6. CNT_W=2 with 5 load-use events -> nop_total saturates at 3. inst_valid=0 cycles give nop_sel=1 and do not increment.
